// File: rtl/bcd_clock_counter_if.sv
// Control and display bundle between the game controller and one mm:ss BCD counter.
// Latency: none (wires only).
// Backpressure: none; strobes are single-cycle and always accepted.
// master: controller side, drives ce/impulse/mode/load/bonus and the preload/bonus values.
// slave : counter side, returns the BCD digits plus zero/flag/wrap status.
interface bcd_clock_counter_if #(
  parameter int MIN_DIGITS = 2
);
  logic                    ce;
  logic                    impulse;
  logic                    mode;
  logic                    load;
  logic [4*MIN_DIGITS-1:0] load_min;
  logic [7:0]              load_sec;
  logic                    bonus;
  logic [7:0]              bonus_sec;
  logic [4*MIN_DIGITS-1:0] min;
  logic [3:0]              sec_tens;
  logic [3:0]              sec_units;
  logic                    zero;
  logic                    flag;
  logic                    wrap;

  modport master (
    output ce, impulse, mode, load, load_min, load_sec, bonus, bonus_sec,
    input  min, sec_tens, sec_units, zero, flag, wrap
  );

  modport slave (
    input  ce, impulse, mode, load, load_min, load_sec, bonus, bonus_sec,
    output min, sec_tens, sec_units, zero, flag, wrap
  );
endinterface

// File: rtl/bcd_clock_counter.sv
// Per-player mm:ss BCD time counter: up/down count, clamped preload, Fischer bonus, flag-fall.
// Latency: 1 clock from any strobe (load, bonus, tick) to the registered outputs.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries controls in and digits/status out.
module bcd_clock_counter #(
  parameter int MIN_DIGITS = 2,
  parameter bit WRAP_UP    = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  bcd_clock_counter_if.slave bus
);
  // The count is held as one packed BCD vector: digit 0 = seconds units,
  // digit 1 = seconds tens (radix 6), digits 2.. = minutes (radix 10).
  localparam int ND = MIN_DIGITS + 2;
  localparam int W  = 4 * ND;

  function automatic logic [3:0] dig_max(input int i);
    return (i == 1) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [W-1:0] max_val();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = dig_max(i);
    return r;
  endfunction

  localparam logic [W-1:0] CNT_MAX = max_val();

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < ND; i++)
      if (v[4*i +: 4] > dig_max(i)) r[4*i +: 4] = dig_max(i);
    return r;
  endfunction

  // Returns {carry_out, v+1}; carry_out means v was the maximum.
  function automatic logic [W:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (c) begin
        if (v[4*i +: 4] == dig_max(i)) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

  // Only used on a non-zero count, so the final borrow is never needed.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < ND; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = dig_max(i);
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Returns {overflow, v+a}; digits of both operands are legal for their radix.
  function automatic logic [W:0] bcd_add(input logic [W-1:0] v, input logic [W-1:0] a);
    logic [W-1:0] r;
    logic [4:0]   s;
    logic         c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < ND; i++) begin
      s = {1'b0, v[4*i +: 4]} + {1'b0, a[4*i +: 4]} + {4'd0, c};
      if (s > {1'b0, dig_max(i)}) begin
        s = s - ({1'b0, dig_max(i)} + 5'd1);
        c = 1'b1;
      end else begin
        c = 1'b0;
      end
      r[4*i +: 4] = s[3:0];
    end
    return {c, r};
  endfunction

  logic [W-1:0] cnt_q, cnt_d;
  logic         flag_q, flag_d;
  logic         wrap_q, wrap_d;
  logic         tick;
  logic [W-1:0] load_v, bonus_v, dec_v;
  logic [W:0]   inc_r, sum_r;

  always_comb begin
    cnt_d   = cnt_q;
    flag_d  = flag_q;
    wrap_d  = 1'b0;
    tick    = bus.ce & bus.impulse;
    load_v  = clamp({bus.load_min, bus.load_sec});
    bonus_v = clamp({{(W-8){1'b0}}, bus.bonus_sec});
    inc_r   = bcd_inc(cnt_q);
    // Bonus and tick are merged: add first, then the tick decrements the sum,
    // so a tick arriving with a bonus is never lost.
    sum_r   = bcd_add(cnt_q, bus.bonus ? bonus_v : '0);
    dec_v   = bcd_dec(sum_r[W-1:0]);

    if (bus.load) begin
      cnt_d  = load_v;
      flag_d = 1'b0;
    end else if (!bus.mode) begin
      if (tick) begin
        if (inc_r[W]) begin
          if (WRAP_UP) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
          end
        end else begin
          cnt_d = inc_r[W-1:0];
        end
      end
    end else if (sum_r[W]) begin
      // Sum beyond range: sum-1 is still >= maximum, so saturate either way.
      cnt_d = CNT_MAX;
    end else if (tick) begin
      if (sum_r[W-1:0] == '0) begin
        flag_d = 1'b1;
      end else begin
        cnt_d = dec_v;
        if (dec_v == '0) flag_d = 1'b1;
      end
    end else begin
      cnt_d = sum_r[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.min       = cnt_q[W-1:8];
  assign bus.sec_tens  = cnt_q[7:4];
  assign bus.sec_units = cnt_q[3:0];
  assign bus.zero      = (cnt_q == '0);
  assign bus.flag      = flag_q;
  assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_bcd_clock_counter.sv
// Bench for bcd_clock_counter: three builds (2 digits wrap, 2 digits saturate, 3 digits wrap)
// share one directed stimulus; a seconds-based model is compared every cycle, plus literal checks.
module tb_bcd_clock_counter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce, impulse, mode, load, bonus;
  logic [11:0] lmin;
  logic [7:0]  lsec, bsec;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bcd_clock_counter_if #(.MIN_DIGITS(2)) if_a ();
  bcd_clock_counter_if #(.MIN_DIGITS(2)) if_s ();
  bcd_clock_counter_if #(.MIN_DIGITS(3)) if_3 ();

  assign if_a.ce = ce;  assign if_a.impulse = impulse;  assign if_a.mode = mode;
  assign if_a.load = load;  assign if_a.load_min = lmin[7:0];  assign if_a.load_sec = lsec;
  assign if_a.bonus = bonus;  assign if_a.bonus_sec = bsec;
  assign if_s.ce = ce;  assign if_s.impulse = impulse;  assign if_s.mode = mode;
  assign if_s.load = load;  assign if_s.load_min = lmin[7:0];  assign if_s.load_sec = lsec;
  assign if_s.bonus = bonus;  assign if_s.bonus_sec = bsec;
  assign if_3.ce = ce;  assign if_3.impulse = impulse;  assign if_3.mode = mode;
  assign if_3.load = load;  assign if_3.load_min = lmin;  assign if_3.load_sec = lsec;
  assign if_3.bonus = bonus;  assign if_3.bonus_sec = bsec;

  bcd_clock_counter #(.MIN_DIGITS(2), .WRAP_UP(1'b1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  bcd_clock_counter #(.MIN_DIGITS(2), .WRAP_UP(1'b0)) dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
  bcd_clock_counter #(.MIN_DIGITS(3), .WRAP_UP(1'b1)) dut_3 (.clk(clk), .rst_n(rst_n), .bus(if_3));

  // Model: count kept as plain total seconds per instance.
  int secs [3] = '{0, 0, 0};
  bit flg  [3] = '{0, 0, 0};
  bit wrp  [3] = '{0, 0, 0};
  int maxv [3] = '{5999, 5999, 59999};
  bit wup  [3] = '{1, 0, 1};
  int ndig [3] = '{2, 2, 3};

  function automatic int min_val(input logic [11:0] x, input int n);
    int v, d, p;
    v = 0;
    p = 1;
    for (int i = 0; i < n; i++) begin
      d = int'(x[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic int sec_val(input logic [7:0] x);
    int t, u;
    t = int'(x[7:4]);
    u = int'(x[3:0]);
    if (t > 5) t = 5;
    if (u > 9) u = 9;
    return t * 10 + u;
  endfunction

  function automatic logic [11:0] to_bcd(input int m);
    return {4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic model_step(input int k);
    int t;
    wrp[k] = 1'b0;
    if (load) begin
      secs[k] = min_val(lmin, ndig[k]) * 60 + sec_val(lsec);
      flg[k]  = 1'b0;
    end else if (!mode) begin
      if (ce && impulse) begin
        if (secs[k] == maxv[k]) begin
          if (wup[k]) begin
            secs[k] = 0;
            wrp[k]  = 1'b1;
          end
        end else begin
          secs[k] = secs[k] + 1;
        end
      end
    end else begin
      t = secs[k] + (bonus ? sec_val(bsec) : 0);
      if (ce && impulse) begin
        if (t == 0) flg[k] = 1'b1;
        else begin
          t = t - 1;
          if (t == 0) flg[k] = 1'b1;
        end
      end
      secs[k] = (t > maxv[k]) ? maxv[k] : t;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        secs[k] = 0;
        flg[k]  = 1'b0;
        wrp[k]  = 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  task automatic cmp_inst(input string name, input int k, input logic [22:0] act);
    logic [22:0] exp;
    exp = {to_bcd(secs[k] / 60), 4'((secs[k] % 60) / 10), 4'(secs[k] % 10),
           secs[k] == 0, flg[k], wrp[k]};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_%s t=%0t got min/st/su/z/f/w=%h required %h", name, $time, act, exp);
    end
  endtask

  // Single compare process: outputs are sampled on the falling edge.
  always @(negedge clk) begin
    cmp_inst("a", 0, {4'h0, if_a.min, if_a.sec_tens, if_a.sec_units, if_a.zero, if_a.flag, if_a.wrap});
    cmp_inst("s", 1, {4'h0, if_s.min, if_s.sec_tens, if_s.sec_units, if_s.zero, if_s.flag, if_s.wrap});
    cmp_inst("3", 2, {if_3.min, if_3.sec_tens, if_3.sec_units, if_3.zero, if_3.flag, if_3.wrap});
  end

  // Literal expectation: {min(12b), tens, units, zero, flag, wrap}.
  task automatic lit(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got %h required %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [22:0] out_a();
    return {4'h0, if_a.min, if_a.sec_tens, if_a.sec_units, if_a.zero, if_a.flag, if_a.wrap};
  endfunction
  function automatic logic [22:0] out_s();
    return {4'h0, if_s.min, if_s.sec_tens, if_s.sec_units, if_s.zero, if_s.flag, if_s.wrap};
  endfunction
  function automatic logic [22:0] out_3();
    return {if_3.min, if_3.sec_tens, if_3.sec_units, if_3.zero, if_3.flag, if_3.wrap};
  endfunction

  // Called on a falling edge; inputs are held for exactly one rising edge.
  task automatic drive(input logic ld, input logic [11:0] lm, input logic [7:0] ls,
                       input logic bn, input logic [7:0] bs, input logic imp);
    load = ld;  lmin = lm;  lsec = ls;
    bonus = bn; bsec = bs;  impulse = imp;
    @(negedge clk);
    load = 1'b0;  bonus = 1'b0;  impulse = 1'b0;
  endtask

  task automatic do_load(input logic [11:0] lm, input logic [7:0] ls);
    drive(1'b1, lm, ls, 1'b0, 8'h00, 1'b0);
  endtask
  task automatic do_tick();
    drive(1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b1);
  endtask
  task automatic do_idle();
    drive(1'b0, 12'h000, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;  ce = 1'b1;  impulse = 1'b0;  mode = 1'b1;
    load = 1'b0;   bonus = 1'b0;  lmin = '0;  lsec = '0;  bsec = '0;
    #3;
    lit("reset_state", out_a(), {12'h000, 4'h0, 4'h0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Load 05:00, one down tick.
    do_load(12'h005, 8'h00);
    lit("load_0500", out_a(), {12'h005, 4'h0, 4'h0, 3'b000});
    do_tick();
    lit("down_0459", out_a(), {12'h004, 4'h5, 4'h9, 3'b000});

    // Flag-fall from 00:02.
    do_load(12'h000, 8'h02);
    do_tick();
    lit("down_0001", out_a(), {12'h000, 4'h0, 4'h1, 3'b000});
    do_tick();
    lit("flag_fall", out_a(), {12'h000, 4'h0, 4'h0, 3'b110});
    do_tick();
    lit("hold_zero", out_a(), {12'h000, 4'h0, 4'h0, 3'b110});
    drive(1'b0, 12'h000, 8'h00, 1'b1, 8'h10, 1'b0);
    lit("bonus_after_flag", out_a(), {12'h000, 4'h1, 4'h0, 3'b010});
    do_load(12'h000, 8'h30);
    lit("load_clears_flag", out_a(), {12'h000, 4'h3, 4'h0, 3'b000});

    // Bonus with tick, then saturating bonus.
    drive(1'b0, 12'h000, 8'h00, 1'b1, 8'h45, 1'b1);
    lit("bonus_tick_0114", out_a(), {12'h001, 4'h1, 4'h4, 3'b000});
    do_load(12'h099, 8'h50);
    drive(1'b0, 12'h000, 8'h00, 1'b1, 8'h59, 1'b0);
    lit("bonus_saturate", out_a(), {12'h099, 4'h5, 4'h9, 3'b000});
    lit("bonus_3digit", out_3(), {12'h100, 4'h4, 4'h9, 3'b000});

    // Up count wrap versus saturate.
    mode = 1'b0;
    do_load(12'h099, 8'h58);
    do_tick();
    lit("up_9959", out_a(), {12'h099, 4'h5, 4'h9, 3'b000});
    do_tick();
    lit("wrap_pulse", out_a(), {12'h000, 4'h0, 4'h0, 3'b101});
    lit("sat_hold", out_s(), {12'h099, 4'h5, 4'h9, 3'b000});
    do_idle();
    lit("wrap_one_cycle", out_a(), {12'h000, 4'h0, 4'h0, 3'b100});

    // Clamp, load-over-tick, CE gating.
    do_load(12'h012, 8'h7C);
    lit("load_clamp", out_a(), {12'h012, 4'h5, 4'h9, 3'b000});
    drive(1'b1, 12'h000, 8'h20, 1'b0, 8'h00, 1'b1);
    lit("load_beats_tick", out_a(), {12'h000, 4'h2, 4'h0, 3'b000});
    ce = 1'b0;
    for (int i = 0; i < 5; i++) do_tick();
    lit("ce_blocks", out_a(), {12'h000, 4'h2, 4'h0, 3'b000});
    mode = 1'b1;
    drive(1'b0, 12'h000, 8'h00, 1'b1, 8'h05, 1'b1);
    lit("ce_off_bonus", out_a(), {12'h000, 4'h2, 4'h5, 3'b000});

    // Asynchronous reset mid-count.
    ce = 1'b1;  mode = 1'b0;
    do_load(12'h012, 8'h34);
    do_tick();
    do_tick();
    lit("up_1236", out_a(), {12'h012, 4'h3, 4'h6, 3'b000});
    #2 rst_n = 1'b0;
    #1;
    lit("async_reset_a", out_a(), {12'h000, 4'h0, 4'h0, 3'b100});
    lit("async_reset_3", out_3(), {12'h000, 4'h0, 4'h0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Three-digit wrap.
    do_load(12'h999, 8'h59);
    lit("load_99959", out_3(), {12'h999, 4'h5, 4'h9, 3'b000});
    do_tick();
    lit("wrap_3digit", out_3(), {12'h000, 4'h0, 4'h0, 3'b101});
    do_idle();
    lit("wrap_3digit_end", out_3(), {12'h000, 4'h0, 4'h0, 3'b100});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
